imu_frame_uart_tx: RTL and testbench
====================================

// Module: imu_frame_uart_tx
// PURPOSE
//  Builds and serializes 11-byte IMU frames (sync 0x55, type, four 16-bit words LSB-first, checksum) on a UART line.
//  Drives the line that the board's frame receiver decodes; used for sensor emulation, loopback and host upload.
//  Frame accepted through a valid/ready handshake; 8N1 serialization by a built-in baud counter (no external clk_bps).
// PARAMETERS
//  CLKS_PER_BIT  217  clk cycles per bit (25 MHz / 115200); legal >= 2
//  STOP_BITS     1    stop bits per byte, 1 or 2
//  GAP_BITS      0    idle-high bit times inserted after each frame before frm_ready returns
// PORTS
//  clk          in   1   system clock
//  rst          in   1   asynchronous, active-high reset
//  frm_valid    in   1   frame request; frm_* fields valid while high
//  frm_ready    out  1   block idle, frame accepted on frm_valid & frm_ready
//  frm_type     in   8   type byte (0x51 accel, 0x52 gyro, 0x53 angle; other values sent unchanged)
//  frm_d0..d3   in   16  payload words d0..d3, sent in order, low byte first
//  uart_tx      out  1   serial line, idle high
//  busy         out  1   high from acceptance until frm_ready returns
//  frame_done   out  1   one-cycle pulse when the last stop bit (plus gap) ends
// BEHAVIOUR
//  Reset: uart_tx=1, frm_ready=1, busy=0, frame_done=0, all counters and the frame buffer cleared.
//  Accept: on frm_valid&frm_ready, capture all fields; frm_ready=0, busy=1 next cycle; frm_valid ignored while busy.
//  Byte order: 0x55, type, d0[7:0], d0[15:8], d1 lo, d1 hi, d2 lo, d2 hi, d3 lo, d3 hi, cksum.
//  cksum = 8-bit sum of bytes 0..9, mod 256 (carries dropped); accumulated while bytes are sent.
//  FSM: IDLE -> START -> DATA(8 bits, LSB first) -> [PARITY] -> STOP -> (byte<10 ? START : GAP) -> IDLE.
//  Start bit drives the line on the first cycle after acceptance; each bit lasts exactly CLKS_PER_BIT cycles.
//  Bytes are back-to-back: next start bit immediately follows the last stop-bit cycle.
//  Frame length: 11*(10+STOP_BITS-1)*CLKS_PER_BIT + GAP_BITS*CLKS_PER_BIT cycles (8N1 with no parity).
//  End: frame_done=1 and frm_ready=1 in the same cycle; frm_valid high then is accepted that cycle (no dead cycle).
//  uart_tx is registered (glitch-free); busy == ~frm_ready.
//  Reset mid-frame: line returns high asynchronously; partial frame discarded; no frame_done.
//  Byte index counter 0..10 saturates at 10; bit counter and baud counter wrap to 0 at every bit or byte boundary.
// CONFIGURATION
//  IMU_TX_PARITY_EN defined: even-parity bit after bit 7 of each byte (parity = ^byte), adds one bit time per byte.
//  IMU_TX_PARITY_EN undefined: plain 8N1, PARITY state absent; frame timing as given above.
// STRUCTURE
//  Package imu_frame_pkg: IMU_SYNC=8'h55, IMU_TYPE_ACC=8'h51, IMU_TYPE_GYRO=8'h52, IMU_TYPE_ANG=8'h53,
//   IMU_FRAME_LEN=11, FSM state enum typedef.
//  Sub-module uart_byte_tx: byte serializer + baud counter (byte_valid/byte_ready, uart_tx); top does sequencing and checksum.
// TESTING  (CLKS_PER_BIT=4, STOP_BITS=1, GAP_BITS=0 unless stated)
//  1 type=0x52, d1=0x1234, others 0 -> bytes 55 52 00 00 34 12 00 00 00 00 ED; frame_done at 440 cycles after acceptance.
//  2 type=0x53, all d=0xFFFF -> checksum wraps to 0xA0; every byte start bit low, stop bit high.
//  3 frm_valid held high for two frames -> second accepted the frame_done cycle; no idle bit between frames.
//  4 frm_valid toggled during frame -> ignored; frm_ready stays 0; frame content unchanged.
//  5 rst asserted at byte 4 bit 3 -> uart_tx=1 immediately, frm_ready=1, no frame_done; next frame starts clean with 0x55.
//  6 IMU_TX_PARITY_EN, byte 0x55 -> parity bit 0; type 0x52 -> parity 1; frame = 11*11*4 cycles; loopback to receiver decodes w_y.

Source files
------------

// File: rtl/imu_frame_pkg.sv
// Shared constants, state types and frame helpers for the IMU frame UART transmitter.
// Optional feature: IMU_TX_PARITY_EN adds an even-parity bit after each data byte.
package imu_frame_pkg;

  localparam logic [7:0] IMU_SYNC      = 8'h55;
  localparam logic [7:0] IMU_TYPE_ACC  = 8'h51;
  localparam logic [7:0] IMU_TYPE_GYRO = 8'h52;
  localparam logic [7:0] IMU_TYPE_ANG  = 8'h53;

  localparam int unsigned IMU_FRAME_LEN = 11;
  localparam int unsigned IMU_LAST_BYTE = IMU_FRAME_LEN - 1;

`ifdef IMU_TX_PARITY_EN
  localparam int unsigned IMU_PARITY_BITS = 1;
`else
  localparam int unsigned IMU_PARITY_BITS = 0;
`endif

  // Per-byte serializer states
  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
`ifdef IMU_TX_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } tx_state_t;

  // Frame sequencer states; FRM_TAIL covers the last byte plus the idle gap
  typedef enum logic [1:0] {
    FRM_IDLE,
    FRM_SEND,
    FRM_TAIL
  } frm_state_t;

  typedef struct packed {
    logic [7:0]  ftype;
    logic [15:0] d3;
    logic [15:0] d2;
    logic [15:0] d1;
    logic [15:0] d0;
  } imu_frame_t;

  // Bit times per byte: start + 8 data + optional parity + stop bits
  function automatic int unsigned bits_per_byte(input int unsigned stop_bits);
    return 9 + IMU_PARITY_BITS + stop_bits;
  endfunction

  function automatic logic [7:0] frame_byte(input imu_frame_t f, input logic [3:0] idx,
                                            input logic [7:0] cksum);
    logic [7:0] b;
    case (idx)
      4'd0:    b = IMU_SYNC;
      4'd1:    b = f.ftype;
      4'd2:    b = f.d0[7:0];
      4'd3:    b = f.d0[15:8];
      4'd4:    b = f.d1[7:0];
      4'd5:    b = f.d1[15:8];
      4'd6:    b = f.d2[7:0];
      4'd7:    b = f.d2[15:8];
      4'd8:    b = f.d3[7:0];
      4'd9:    b = f.d3[15:8];
      4'd10:   b = cksum;
      default: b = IMU_SYNC;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// Byte serializer with built-in baud counter; byte_ready is high while idle and during the
// final stop-bit cycle so a new byte's start bit follows immediately. Parity via IMU_TX_PARITY_EN.
module uart_byte_tx
  import imu_frame_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 217,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       byte_ready,
  output logic       uart_tx
);

  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

  tx_state_t         state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shreg_q, shreg_d;
  logic              tx_q, tx_d;
  logic              ready_q, ready_d;
`ifdef IMU_TX_PARITY_EN
  logic              par_q, par_d;
`endif

  logic bit_end_c;
  logic load_c;

  assign bit_end_c  = (baud_q == BAUD_LAST);
  assign load_c     = byte_valid & ready_q;
  assign byte_ready = ready_q;
  assign uart_tx    = tx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= TX_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
`ifdef IMU_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
`ifdef IMU_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + BAUD_W'(1);
    bit_d   = bit_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
`ifdef IMU_TX_PARITY_EN
    par_d   = par_q;
`endif

    case (state_q)
      TX_IDLE: begin
        baud_d = '0;
        tx_d   = 1'b1;
      end
      TX_START: begin
        if (bit_end_c) begin
          state_d = TX_DATA;
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shreg_q[0];
        end
      end
      TX_DATA: begin
        if (bit_end_c) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            bit_d = '0;
`ifdef IMU_TX_PARITY_EN
            state_d = TX_PARITY;
            tx_d    = par_q;
`else
            state_d = TX_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d   = bit_q + 3'd1;
            shreg_d = {1'b0, shreg_q[7:1]};
            tx_d    = shreg_q[1];
          end
        end
      end
`ifdef IMU_TX_PARITY_EN
      TX_PARITY: begin
        if (bit_end_c) begin
          state_d = TX_STOP;
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = 1'b1;
        end
      end
`endif
      TX_STOP: begin
        if (bit_end_c) begin
          baud_d = '0;
          if (bit_q == STOP_LAST) begin
            state_d = TX_IDLE;
            bit_d   = '0;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = TX_IDLE;
        baud_d  = '0;
        bit_d   = '0;
        tx_d    = 1'b1;
      end
    endcase

    // A new byte can only arrive while idle or in the final stop-bit cycle
    if (load_c) begin
      state_d = TX_START;
      baud_d  = '0;
      bit_d   = '0;
      shreg_d = byte_data;
      tx_d    = 1'b0;
`ifdef IMU_TX_PARITY_EN
      par_d   = ^byte_data;
`endif
    end

    ready_d = (state_d == TX_IDLE) ||
              ((state_d == TX_STOP) && (bit_d == STOP_LAST) && (baud_d == BAUD_LAST));
  end

endmodule

// File: rtl/imu_frame_uart_tx.sv
// IMU frame builder: captures a frame on valid/ready, feeds 11 bytes to the serializer and
// appends the running checksum. Optional parity per byte via IMU_TX_PARITY_EN.
module imu_frame_uart_tx
  import imu_frame_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 217,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned GAP_BITS     = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frm_valid,
  output logic        frm_ready,
  input  logic [7:0]  frm_type,
  input  logic [15:0] frm_d0,
  input  logic [15:0] frm_d1,
  input  logic [15:0] frm_d2,
  input  logic [15:0] frm_d3,
  output logic        uart_tx,
  output logic        busy,
  output logic        frame_done
);

  localparam int unsigned BYTE_CLKS = bits_per_byte(STOP_BITS) * CLKS_PER_BIT;
  localparam int unsigned TAIL_CLKS = BYTE_CLKS + GAP_BITS * CLKS_PER_BIT;
  localparam int unsigned TAIL_W    = $clog2(TAIL_CLKS);
  localparam logic [TAIL_W-1:0] TAIL_PRE  = TAIL_W'(TAIL_CLKS - 2);
  localparam logic [TAIL_W-1:0] TAIL_LAST = TAIL_W'(TAIL_CLKS - 1);

  frm_state_t        fstate_q, fstate_d;
  imu_frame_t        frame_q, frame_d;
  logic [3:0]        idx_q, idx_d;
  logic [7:0]        cksum_q, cksum_d;
  logic [TAIL_W-1:0] tail_q, tail_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic       accept_c;
  logic       byte_valid_c;
  logic [7:0] byte_data_c;
  logic       byte_ready;

  assign accept_c   = frm_valid & ready_q;
  assign frm_ready  = ready_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

  uart_byte_tx #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .STOP_BITS    (STOP_BITS)
  ) u_byte_tx (
    .clk        (clk),
    .rst        (rst),
    .byte_valid (byte_valid_c),
    .byte_data  (byte_data_c),
    .byte_ready (byte_ready),
    .uart_tx    (uart_tx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fstate_q <= FRM_IDLE;
      frame_q  <= '0;
      idx_q    <= '0;
      cksum_q  <= '0;
      tail_q   <= '0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      fstate_q <= fstate_d;
      frame_q  <= frame_d;
      idx_q    <= idx_d;
      cksum_q  <= cksum_d;
      tail_q   <= tail_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    fstate_d     = fstate_q;
    frame_d      = frame_q;
    idx_d        = idx_q;
    cksum_d      = cksum_q;
    tail_d       = tail_q;
    ready_d      = ready_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    byte_valid_c = 1'b0;
    byte_data_c  = frame_byte(frame_q, idx_q, cksum_q);

    case (fstate_q)
      FRM_IDLE: begin
        tail_d = '0;
      end
      FRM_SEND: begin
        byte_valid_c = 1'b1;
        if (byte_ready) begin
          if (idx_q == 4'(IMU_LAST_BYTE)) begin
            fstate_d = FRM_TAIL;
            tail_d   = '0;
          end else begin
            cksum_d = cksum_q + byte_data_c;
            idx_d   = idx_q + 4'd1;
          end
        end
      end
      FRM_TAIL: begin
        // Ready/done rise for the final cycle of the last stop bit (or gap)
        tail_d = tail_q + TAIL_W'(1);
        if (tail_q == TAIL_PRE) begin
          ready_d = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
        if (tail_q == TAIL_LAST) begin
          fstate_d = FRM_IDLE;
          tail_d   = '0;
        end
      end
      default: begin
        fstate_d = FRM_IDLE;
        ready_d  = 1'b1;
        busy_d   = 1'b0;
      end
    endcase

    // Sync byte is handed over on the acceptance edge so the start bit follows at once
    if (accept_c) begin
      frame_d.ftype = frm_type;
      frame_d.d0    = frm_d0;
      frame_d.d1    = frm_d1;
      frame_d.d2    = frm_d2;
      frame_d.d3    = frm_d3;
      fstate_d      = FRM_SEND;
      idx_d         = 4'd1;
      cksum_d       = IMU_SYNC;
      tail_d        = '0;
      ready_d       = 1'b0;
      busy_d        = 1'b1;
      byte_valid_c  = 1'b1;
      byte_data_c   = IMU_SYNC;
    end
  end

endmodule

// File: tb/tb_imu_frame_uart_tx.sv
// Bench for imu_frame_uart_tx: directed and random frames checked cycle by cycle against a
// frame/line model built from the byte-order and framing rules (honours IMU_TX_PARITY_EN).
module tb_imu_frame_uart_tx;

  localparam int CPB = 4;
  localparam int SB  = 1;
  localparam int GAP = 0;
`ifdef IMU_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int BPB = 9 + PB + SB;
  localparam int FL  = 11 * BPB * CPB + GAP * CPB;

  logic        clk;
  logic        rst;
  logic        frm_valid;
  logic        frm_ready;
  logic [7:0]  frm_type;
  logic [15:0] frm_d0, frm_d1, frm_d2, frm_d3;
  logic        uart_tx;
  logic        busy;
  logic        frame_done;

  int total = 0;
  int bad   = 0;
  int fnum  = 0;
  logic [7:0] eb [11];

  imu_frame_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .STOP_BITS    (SB),
    .GAP_BITS     (GAP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .frm_valid  (frm_valid),
    .frm_ready  (frm_ready),
    .frm_type   (frm_type),
    .frm_d0     (frm_d0),
    .frm_d1     (frm_d1),
    .frm_d2     (frm_d2),
    .frm_d3     (frm_d3),
    .uart_tx    (uart_tx),
    .busy       (busy),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected frame bytes from the field values
  task automatic build(input logic [7:0] t, input logic [15:0] d0, input logic [15:0] d1,
                       input logic [15:0] d2, input logic [15:0] d3);
    int s;
    eb[0] = 8'h55;  eb[1] = t;
    eb[2] = d0[7:0]; eb[3] = d0[15:8];
    eb[4] = d1[7:0]; eb[5] = d1[15:8];
    eb[6] = d2[7:0]; eb[7] = d2[15:8];
    eb[8] = d3[7:0]; eb[9] = d3[15:8];
    s = 0;
    for (int i = 0; i < 10; i++) s += int'(eb[i]);
    eb[10] = 8'(s % 256);
  endtask

  // Line level k cycles after acceptance
  function automatic logic exp_line(input int k);
    int b, i, j;
    logic [7:0] v;
    b = k / CPB;
    if (b >= 11 * BPB) return 1'b1;
    i = b / BPB;
    j = b % BPB;
    v = eb[i];
    if (j == 0) return 1'b0;
    if (j <= 8) return v[j-1];
    if (PB == 1 && j == 9) return ^v;
    return 1'b1;
  endfunction

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle_line", 32'(uart_tx), 32'd1);
      check("idle_ready", 32'(frm_ready), 32'd1);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_done", 32'(frame_done), 32'd0);
    end
  endtask

  // mode 0: drop valid after acceptance; 1: junk valid/fields while busy; 2: hold valid for chaining
  task automatic run_frame(input logic [7:0] t, input logic [15:0] d0, input logic [15:0] d1,
                           input logic [15:0] d2, input logic [15:0] d3, input int mode,
                           input int abort_at);
    logic fin;
    fnum++;
    check($sformatf("ready_before f%0d", fnum), 32'(frm_ready), 32'd1);
    build(t, d0, d1, d2, d3);
    frm_valid = 1'b1; frm_type = t;
    frm_d0 = d0; frm_d1 = d1; frm_d2 = d2; frm_d3 = d3;
    @(posedge clk);
    for (int k = 0; k < FL; k++) begin
      @(negedge clk);
      if (k == abort_at) begin
        rst = 1'b1;
        #1;
        check("rst_line", 32'(uart_tx), 32'd1);
        check("rst_ready", 32'(frm_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        frm_valid = 1'b0;
        @(negedge clk);
        check("rst_done_hold", 32'(frame_done), 32'd0);
        rst = 1'b0;
        return;
      end
      fin = (k == FL - 1);
      check($sformatf("line f%0d c%0d", fnum, k), 32'(uart_tx), 32'(exp_line(k)));
      check($sformatf("ready f%0d c%0d", fnum, k), 32'(frm_ready), 32'(fin));
      check($sformatf("busy f%0d c%0d", fnum, k), 32'(busy), 32'(!fin));
      check($sformatf("done f%0d c%0d", fnum, k), 32'(frame_done), 32'(fin));
      if (k < FL - 2) begin
        if (mode == 0) begin
          frm_valid = 1'b0;
        end else if (mode == 1) begin
          frm_valid = 1'($urandom);
          frm_type  = 8'($urandom);
          frm_d0 = 16'($urandom); frm_d1 = 16'($urandom);
          frm_d2 = 16'($urandom); frm_d3 = 16'($urandom);
        end
      end else if (mode != 2) begin
        frm_valid = 1'b0;
      end
    end
  endtask

  function automatic logic [7:0] rand_type();
    logic [7:0] types [4];
    types[0] = 8'h51; types[1] = 8'h52; types[2] = 8'h53; types[3] = 8'($urandom);
    return types[$urandom_range(0, 3)];
  endfunction

  initial begin
    rst = 1'b1; frm_valid = 1'b0; frm_type = '0;
    frm_d0 = '0; frm_d1 = '0; frm_d2 = '0; frm_d3 = '0;
    repeat (3) @(negedge clk);
    check("reset_line", 32'(uart_tx), 32'd1);
    check("reset_ready", 32'(frm_ready), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(frame_done), 32'd0);
    rst = 1'b0;
    idle_check(3);

    // gyro frame, d1 only: checksum 0xED
    run_frame(8'h52, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 0, -1);
    idle_check(2);

    // all-ones payload: checksum wraps to 0xA0
    run_frame(8'h53, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 0, -1);
    idle_check(2);

    // valid held high: second frame accepted on the frame_done cycle
    run_frame(rand_type(), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 2, -1);
    run_frame(rand_type(), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 0, -1);
    idle_check(2);

    // valid and fields toggled while busy must be ignored
    run_frame(rand_type(), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 1, -1);
    idle_check(2);

    // reset during byte 4, data bit 3; next frame must start clean
    run_frame(8'h51, 16'hA5C3, 16'h0F0F, 16'h1357, 16'hFEDC, 0, 4 * BPB * CPB + 4 * CPB + 1);
    check("post_rst_line", 32'(uart_tx), 32'd1);
    check("post_rst_ready", 32'(frm_ready), 32'd1);
    run_frame(8'h52, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 0, -1);
    idle_check(1);

    for (int n = 0; n < 4; n++) begin
      run_frame(rand_type(), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                (n == 1) ? 2 : 0, -1);
      if (n != 1) idle_check(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
